// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multu/divu sequencer driving a shared ALU
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctr,
  input  logic [31:0] alu_res
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] dvs, hi_n, lo_n, r;
  logic [4:0] cnt;
  logic op_r, dbz_n, accept, dz, step, q;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    r = {hi[30:0], lo[31]};
    q = !(r < dvs);
    accept = state != RUN && start;
    dz = op && opb == 32'd0;
    step = state == RUN && alu_gnt;
    alu_req = state == RUN;
    alu_ctr = (state == RUN && op_r) ? 4'b0110 : 4'b0010;
    alu_a = state != RUN ? 32'd0 : op_r ? r : hi;
    alu_b = state != RUN ? 32'd0 : (op_r || lo[0]) ? dvs : 32'd0;
    state_n = state == DONE ? IDLE : state;
    hi_n = hi;
    lo_n = lo;
    dbz_n = div_by_zero;
    if (accept) begin
      hi_n = dz ? opa : 32'd0;
      lo_n = dz ? 32'hFFFF_FFFF : opa;
      dbz_n = dz;
      state_n = dz ? DONE : RUN;
    end else if (step) begin
      // divu: restoring step; multu: shift-add with carry recovered by compare
      hi_n = op_r ? (q ? alu_res : r) : {alu_res < hi, alu_res[31:1]};
      lo_n = op_r ? {lo[30:0], q} : {alu_res[0], lo[31:1]};
      state_n = cnt == 5'd31 ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
      dvs <= '0;
      op_r <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      hi <= hi_n;
      lo <= lo_n;
      div_by_zero <= dbz_n;
      if (accept) begin
        op_r <= op;
        dvs <= opb;
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with an expected-result scoreboard for muldiv_seq
module tb_muldiv_seq;
  logic clk, reset, start, op, alu_gnt;
  logic [31:0] opa, opb, alu_res, alu_a, alu_b, hi, lo;
  logic [3:0] alu_ctr;
  logic busy, done, div_by_zero, alu_req;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dbz;} exp_t;
  exp_t sb[$];

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctr(alu_ctr), .alu_res(alu_res)
  );

  // shared ALU: subtract on 0110, add otherwise
  assign alu_res = (alu_ctr == 4'b0110) ? alu_a - alu_b : alu_a + alu_b;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: compare each done pulse against the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
        chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
        chk("result_dbz", {63'd0, div_by_zero}, {63'd0, e.dbz});
      end
    end
  end

  task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed, input bit push);
    @(negedge clk);
    start = 1; op = o; opa = a; opb = b;
    if (push) sb.push_back('{hi: eh, lo: el, dbz: ed});
    @(posedge clk);
    #1 start = 0;
  endtask

  // walks cycles until done; lat counts edges from the start edge inclusive
  task automatic wait_done(input int maxc, input bit alt, output int lat, output int reqs);
    bit denied = 0, seen = 0;
    logic [31:0] ph = 0, pl = 0;
    lat = 1;
    reqs = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (denied) chk("stall_freeze", {hi, lo}, {ph, pl});
      if (done) begin
        seen = 1;
        break;
      end
      reqs += int'(alu_req);
      alu_gnt = alt ? (k % 2 == 0) : 1'b1;
      denied = alt && busy && (k % 2 != 0);
      ph = hi;
      pl = lo;
      lat++;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_hi_lo", {hi, lo}, 64'd0);
    chk("rst_dbz_req", {62'd0, div_by_zero, alu_req}, 64'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_alu_ctr", {60'd0, alu_ctr}, 64'd2);
  endtask

  initial begin
    int lat, reqs;
    reset = 1; start = 0; op = 0; opa = 0; opb = 0; alu_gnt = 1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 0;
    @(negedge clk);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    launch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1);
    wait_done(100, 0, lat, reqs);
    chk("mul_max_latency", lat, 33);
    chk("mul_max_req_cycles", reqs, 32);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    chk("result_hold", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    launch(1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1);
    wait_done(100, 0, lat, reqs);
    chk("div_latency", lat, 33);
    launch(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 0, 1);
    wait_done(100, 0, lat, reqs);

    launch(1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1);
    wait_done(100, 0, lat, reqs);
    chk("dbz_latency", lat, 1);
    chk("dbz_no_req", reqs, 0);
    repeat (3) @(negedge clk);
    chk("dbz_held", {63'd0, div_by_zero}, 64'd1);

    launch(0, 32'd3, 32'd5, 32'd0, 32'd15, 0, 1);
    wait_done(200, 1, lat, reqs);
    chk("stall_latency", lat, 65);
    chk("stall_req_cycles", reqs, 64);
    alu_gnt = 1;
    launch(0, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 0, 1);
    wait_done(100, 0, lat, reqs);

    launch(0, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 0, 1);
    repeat (5) @(negedge clk);
    start = 1; op = 1; opa = 32'd7; opb = 32'd0;
    @(negedge clk);
    start = 0;
    chk("start_ignored_busy", {62'd0, busy, div_by_zero}, 64'd2);
    wait_done(100, 0, lat, reqs);
    chk("start_ignored_latency", lat, 27);

    launch(1, 32'hDEAD_BEEF, 32'd3, 32'd0, 32'd0, 0, 0);
    repeat (11) @(negedge clk);
    reset = 1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    chk("post_abort_idle", {62'd0, busy, done}, 64'd0);

    launch(1, 32'd1000, 32'd10, 32'd0, 32'd100, 0, 1);
    wait_done(100, 0, lat, reqs);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
